serial_adder_ctrl: RTL and testbench
====================================

# serial_adder_ctrl

Bit-serial addition controller that time-multiplexes a single `full_adder` cell to add two WIDTH-bit operands, one bit per clock, LSB first. It replaces a WIDTH-cell ripple chain where area matters more than latency. It is a start/busy/done sequencer placed between a requesting block and the shared one-bit adder cell.

## Interface

- `WIDTH`, default 4, operand and result width in bits; legal range is ≥ 2.
- `clk`  in  1  rising-edge clock, single clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `start`  in  1  request; sampled only when not busy.
- `a`  in  WIDTH  operand A; captured on an accepted `start`.
- `b`  in  WIDTH  operand B; captured on an accepted `start`.
- `cin`  in  1  carry-in; captured on an accepted `start`.
- `busy`  out  1  high while the addition is in progress.
- `done`  out  1  single-cycle completion pulse.
- `sum`  out  WIDTH  registered result; holds its value between operations.
- `cout`  out  1  registered final carry; holds its value between operations.

## Operation

- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `start`=1.
  - Load shift registers `a_sh`←`a` and `b_sh`←`b`.
  - Load the carry flop ←`cin`.
  - Load the bit counter ←0.
- RUN, each cycle:
  - Feed `a_sh[0]`, `b_sh[0]` and the carry flop into the `full_adder` cell.
  - Shift `a_sh` and `b_sh` right by one.
  - Shift the cell's sum bit into the MSB of the internal `s_sh` register, which shifts right.
  - Carry flop ← cell's cout.
  - Counter increments.
- RUN → DONE on the cycle where counter = WIDTH-1.
  - On that same edge, `sum` ← final `s_sh` contents (including that cycle's sum bit).
  - On that same edge, `cout` ← that cycle's cell cout.
- DONE → RUN if `start`=1, which allows back-to-back operations with new operands captured. Otherwise DONE → IDLE.
- `start` while in RUN is ignored; operands are not re-captured.
- `busy` = (state == RUN). `done` = (state == DONE).
- `sum`/`cout` change only on the RUN→DONE edge. They are stable during RUN and show the previous result.
- Arithmetic: {`cout`,`sum`} = `a` + `b` + `cin`, modulo 2^(WIDTH+1), unsigned. Wrap-around appears solely as `cout`=1.
- Reset (`rst_n`=0 at a rising edge), from any state including mid-RUN:
  - State → IDLE.
  - `busy`, `done`, `sum`, `cout`, shift registers, counter and carry all → 0.
  - An aborted operation produces no `done`.
- Reset takes priority over `start` in the same cycle.

## Timing

- Edge 0: `start` accepted. `busy`=1 from edge 0 through edge WIDTH.
- Edges 1..WIDTH: one result bit per edge.
- Edge WIDTH: `sum`/`cout` update and `done`=1 for exactly one cycle. Latency from start acceptance to `done` is WIDTH cycles.
- Back-to-back throughput is one result per WIDTH+1 cycles (`start` asserted during DONE).
- After reset release: all outputs are 0 and state is IDLE. The first `start` is accepted at the first edge with `rst_n`=1.
- `a`/`b`/`cin` may change freely after edge 0.

## Structure

- Package `serial_adder_pkg` holds:
  - the state enum `{IDLE, RUN, DONE}`, 2-bit encoding;
  - the counter-width constant, defined as $clog2(WIDTH).
- One sub-module instance: the existing `full_adder` cell (sum, cout, a, b, cin), instantiated once.
- All sequential logic sits in the controller: FSM, counter, shift registers, carry flop and output registers.

## Test plan

- WIDTH=4, `a`=0011, `b`=0101, `cin`=0, single `start` pulse → `busy`=1 for 4 cycles, then `done`=1 for 1 cycle with `sum`=1000 and `cout`=0.
- `a`=1111, `b`=1111, `cin`=0 → `sum`=1110, `cout`=1. Then `a`=1111, `b`=0000, `cin`=1 → `sum`=0000, `cout`=1, checking wrap-around.
- During RUN of 0001+0110, drive `start` with `a`=1000, `b`=1001 → ignored; result is `sum`=0111, `cout`=0, and `sum` holds its prior value until the `done` edge.
- `start` held high continuously, operands 1000+1001 then 0010+0010 → `done` pulses at cycles 4 and 9. Results are `sum`=0001/`cout`=1, then `sum`=0100/`cout`=0.
- `rst_n`=0 at RUN cycle 2 of 1111+1111 → next edge: state IDLE and all outputs 0; `done` never asserts. A new `start` after release completes normally.
- WIDTH=8: random sweep of 1000 operand/`cin` triples checked against the `a`+`b`+`cin` reference model. Also check that `done` arrives exactly 8 cycles after acceptance.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the serial adder controller.
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell shared by the serial adder controller.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell reused LSB-first over WIDTH cycles,
// with a start/busy/done handshake and registered result.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input logic               clk,
    input logic               rst_n,
    serial_adder_ctrl_if.slave bus
);
    localparam int unsigned CntW = cnt_width(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  s_sh_q, s_sh_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic              load;
    logic              fa_sum, fa_cout;

    full_adder u_full_adder (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        load    = 1'b0;

        unique case (state_q)
            IDLE: load = bus.start;
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                s_sh_d  = {fa_sum, s_sh_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CntW'(1);
                // Last bit: publish the result including this cycle's sum bit.
                if (cnt_q == LastCnt) begin
                    state_d = DONE;
                    sum_d   = {fa_sum, s_sh_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                end
            end
            DONE: begin
                load    = bus.start;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = RUN;
            a_sh_d  = bus.a;
            b_sh_d  = bus.b;
            s_sh_d  = '0;
            carry_d = bus.cin;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=4 and WIDTH=8.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_ctrl_if #(.WIDTH(4)) bus4 ();
    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();

    serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus4.slave)
    );

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8.slave)
    );

    typedef struct {
        logic [8:0]  res;
        int unsigned due;
    } exp_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
    } vec_t;

    exp_t q4[$];
    exp_t q8[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Called at a negedge; the next posedge accepts the request.
    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c,
                          input logic [3:0] esum, input logic ecout);
        exp_t e;
        bus4.start = 1'b1;
        bus4.a     = a;
        bus4.b     = b;
        bus4.cin   = c;
        e.res      = {4'b0, ecout, esum};
        e.due      = cyc + 1 + 4;
        q4.push_back(e);
    endtask

    // Called at the negedge following acceptance; returns at the negedge showing done.
    task automatic wait_done4(input string name, output int nbusy);
        exp_t e;
        bit   seen = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus4.done) begin
                seen = 1'b1;
                break;
            end
            if (bus4.busy) nbusy++;
            @(negedge clk);
        end
        check({name, " done seen"}, 32'(seen), 32'd1);
        if (q4.size() == 0) begin
            check({name, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = q4.pop_front();
            if (seen) begin
                check({name, " latency"}, cyc, e.due);
                check({name, " sum"}, 32'(bus4.sum), 32'(e.res[3:0]));
                check({name, " cout"}, 32'(bus4.cout), 32'(e.res[4]));
            end
        end
    endtask

    initial begin
        vec_t        vecs[7];
        int          nb;
        logic [3:0]  prev_sum;
        logic        prev_cout;
        bit          saw_done;
        bit          seen;
        logic [7:0]  ra, rb;
        logic        rc;
        exp_t        e;

        vecs[0] = '{a: 4'b0011, b: 4'b0101, cin: 1'b0, sum: 4'b1000, cout: 1'b0};
        vecs[1] = '{a: 4'b1111, b: 4'b1111, cin: 1'b0, sum: 4'b1110, cout: 1'b1};
        vecs[2] = '{a: 4'b1111, b: 4'b0000, cin: 1'b1, sum: 4'b0000, cout: 1'b1};
        vecs[3] = '{a: 4'b0000, b: 4'b0000, cin: 1'b0, sum: 4'b0000, cout: 1'b0};
        vecs[4] = '{a: 4'b0111, b: 4'b0001, cin: 1'b1, sum: 4'b1001, cout: 1'b0};
        vecs[5] = '{a: 4'b1010, b: 4'b0101, cin: 1'b1, sum: 4'b0000, cout: 1'b1};
        vecs[6] = '{a: 4'b1001, b: 4'b0110, cin: 1'b0, sum: 4'b1111, cout: 1'b0};

        rst_n = 1'b0;
        bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
        repeat (3) @(negedge clk);

        check("rst busy4", 32'(bus4.busy), 32'd0);
        check("rst done4", 32'(bus4.done), 32'd0);
        check("rst sum4", 32'(bus4.sum), 32'd0);
        check("rst cout4", 32'(bus4.cout), 32'd0);
        check("rst busy8", 32'(bus8.busy), 32'd0);
        check("rst sum8", 32'(bus8.sum), 32'd0);

        // First start accepted on the first edge with reset released.
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            issue4(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);
            @(negedge clk);
            bus4.start = 1'b0;
            wait_done4($sformatf("vec%0d", i), nb);
            check($sformatf("vec%0d busy cycles", i), 32'(nb), 32'd4);
            @(negedge clk);
            check($sformatf("vec%0d done pulse", i), 32'(bus4.done), 32'd0);
        end
        prev_sum  = vecs[6].sum;
        prev_cout = vecs[6].cout;

        // Start during RUN is ignored; result registers hold the prior value.
        issue4(4'b0001, 4'b0110, 1'b0, 4'b0111, 1'b0);
        @(negedge clk);
        bus4.a = 4'b1000; bus4.b = 4'b1001; bus4.cin = 1'b1;
        for (int i = 0; i < 2; i++) begin
            check("run hold sum", 32'(bus4.sum), 32'(prev_sum));
            check("run hold cout", 32'(bus4.cout), 32'(prev_cout));
            @(negedge clk);
        end
        bus4.start = 1'b0;
        wait_done4("ignore start", nb);
        @(negedge clk);
        check("ignore start idle", 32'(bus4.busy), 32'd0);

        // Start held high: back-to-back operations.
        issue4(4'b1000, 4'b1001, 1'b0, 4'b0001, 1'b1);
        @(negedge clk);
        wait_done4("b2b first", nb);
        issue4(4'b0010, 4'b0010, 1'b0, 4'b0100, 1'b0);
        @(negedge clk);
        bus4.start = 1'b0;
        wait_done4("b2b second", nb);
        @(negedge clk);

        // Reset during RUN aborts without a done pulse.
        issue4(4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1);
        @(negedge clk);
        bus4.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort busy", 32'(bus4.busy), 32'd0);
        check("abort done", 32'(bus4.done), 32'd0);
        check("abort sum", 32'(bus4.sum), 32'd0);
        check("abort cout", 32'(bus4.cout), 32'd0);
        rst_n = 1'b1;
        q4.delete();
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus4.done) saw_done = 1'b1;
        end
        check("abort no done", 32'(saw_done), 32'd0);
        issue4(4'b0110, 4'b0011, 1'b1, 4'b1010, 1'b0);
        @(negedge clk);
        bus4.start = 1'b0;
        wait_done4("after abort", nb);
        @(negedge clk);

        // WIDTH=8 random sweep against a + b + cin.
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            rc = 1'($urandom_range(1));
            bus8.start = 1'b1; bus8.a = ra; bus8.b = rb; bus8.cin = rc;
            e.res = 9'(ra) + 9'(rb) + 9'(rc);
            e.due = cyc + 1 + 8;
            q8.push_back(e);
            @(negedge clk);
            bus8.start = 1'b0;
            bus8.a = 8'($urandom_range(255));
            seen = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (bus8.done) begin
                    seen = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            e = q8.pop_front();
            if (!seen) begin
                check($sformatf("rand%0d done seen", n), 32'd0, 32'd1);
            end else begin
                check($sformatf("rand%0d latency", n), cyc, e.due);
                check($sformatf("rand%0d result", n), 32'({bus8.cout, bus8.sum}), 32'(e.res));
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
